// File: rtl/setup_pkg.sv
// Shared types and constants for the electronic lock setup controller.
// Stored PINs keep the last typed digit in digits[0]; unused nibbles are 0xF.
package setup_pkg;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef struct packed {
    logic [19:0][3:0] digits;
  } senhaPac_t;

  typedef struct packed {
    logic [3:0] BCD5;
    logic [3:0] BCD4;
    logic [3:0] BCD3;
    logic [3:0] BCD2;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
  } bcdPac_t;

  typedef struct packed {
    logic       bip_status;
    logic [6:0] bip_time;
    logic [6:0] lock_time;
    senhaPac_t  master;
    senhaPac_t  pin1;
    senhaPac_t  pin2;
    senhaPac_t  pin3;
    senhaPac_t  pin4;
  } setupPac_t;

  // Binary 0..99 to {tens, ones} BCD nibbles.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [6:0] tens;
    logic [6:0] ones;
    tens = v / 7'd10;
    ones = v % 7'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

endpackage

// File: rtl/setup_entry_parse.sv
// Combinational decode of the keypad buffer: key, entered digits, length and
// the decimal value of a one- or two-digit entry.
module setup_entry_parse
  import setup_pkg::*;
(
  input  senhaPac_t  entry_i,
  output logic [3:0] key_o,
  output logic [4:0] len_o,
  output logic       all_dec_o,
  output senhaPac_t  value_o,
  output logic [6:0] dec_o
);

  logic       stop;
  logic [4:0] len_c;
  logic       dec_c;
  senhaPac_t  val_c;

  always_comb begin
    stop  = 1'b0;
    len_c = 5'd0;
    dec_c = 1'b1;
    val_c = '1;
    // The entry ends at the first empty nibble above the key slot.
    for (int i = 1; i < 20; i++) begin
      if (!stop) begin
        if (entry_i.digits[i] == KEY_NONE) begin
          stop = 1'b1;
        end else begin
          val_c.digits[i-1] = entry_i.digits[i];
          len_c = len_c + 5'd1;
          if (entry_i.digits[i] > 4'd9) dec_c = 1'b0;
        end
      end
    end
  end

  always_comb begin
    case (len_c)
      5'd1:    dec_o = {3'b000, entry_i.digits[1]};
      5'd2:    dec_o = 7'(entry_i.digits[2]) * 7'd10 + {3'b000, entry_i.digits[1]};
      default: dec_o = 7'd0;
    endcase
  end

  assign key_o     = entry_i.digits[0];
  assign len_o     = len_c;
  assign all_dec_o = dec_c;
  assign value_o   = val_c;

endmodule

// File: rtl/setup.sv
// Setup-mode controller: master PIN authentication, eight configuration
// screens on the BCD display, and publication of the configuration record.
module setup
  import setup_pkg::*;
#(
  parameter int          DEF_BIP_TIME  = 5,
  parameter int          DEF_LOCK_TIME = 5,
  parameter int          MIN_TIME      = 5,
  parameter int          MAX_TIME      = 60,
  parameter logic [15:0] DEF_MASTER    = 16'h1234
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      setup_on,
  input  senhaPac_t digitos_value,
  input  logic      digitos_valid,
  output logic      display_en,
  output bcdPac_t   bcd_pac,
  output setupPac_t data_setup_new,
  output logic      data_setup_ok
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AUTH = 2'd1;
  localparam logic [1:0] ST_CFG  = 2'd2;

  localparam logic [6:0] MIN_T  = 7'(MIN_TIME);
  localparam logic [6:0] MAX_T  = 7'(MAX_TIME);
  localparam logic [6:0] DEF_BT = 7'(DEF_BIP_TIME);
  localparam logic [6:0] DEF_LT = 7'(DEF_LOCK_TIME);

  logic [1:0] state_q, state_d;
  logic [2:0] scr_q, scr_d;
  setupPac_t  cfg_q, cfg_d;
  bcdPac_t    bcd_q, bcd_d;
  logic       en_q, en_d;
  logic       ok_q, ok_d;

  logic [3:0] key;
  logic [4:0] len;
  logic       all_dec;
  senhaPac_t  value;
  logic [6:0] dec;
  logic       bip_ok, time_ok, pin_ok;

  setup_entry_parse u_parse (
    .entry_i   (digitos_value),
    .key_o     (key),
    .len_o     (len),
    .all_dec_o (all_dec),
    .value_o   (value),
    .dec_o     (dec)
  );

  function automatic setupPac_t default_cfg();
    setupPac_t c;
    c            = '1;
    c.bip_status = 1'b1;
    c.bip_time   = DEF_BT;
    c.lock_time  = DEF_LT;
    for (int i = 0; i < 4; i++) c.master.digits[i] = DEF_MASTER[4*i +: 4];
    return c;
  endfunction

  function automatic bcdPac_t screen_bcd(input logic [1:0] st, input logic [2:0] scr,
                                         input setupPac_t c);
    bcdPac_t    b;
    senhaPac_t  p;
    logic [7:0] t;
    b = '1;
    p = '1;
    t = 8'h00;
    if (st == ST_AUTH) begin
      b.BCD5 = 4'd0;
    end else if (st == ST_CFG) begin
      b.BCD5 = {1'b0, scr} + 4'd1;
      case (scr)
        3'd0:    b.BCD0 = {3'b000, c.bip_status};
        3'd1:    t = bin2bcd(c.bip_time);
        3'd2:    t = bin2bcd(c.lock_time);
        3'd3:    p = c.master;
        3'd4:    p = c.pin1;
        3'd5:    p = c.pin2;
        3'd6:    p = c.pin3;
        default: p = c.pin4;
      endcase
      if (scr == 3'd1 || scr == 3'd2) begin
        b.BCD0 = t[3:0];
        if (t[7:4] != 4'd0) b.BCD1 = t[7:4];
      end else if (scr != 3'd0) begin
        b.BCD0 = p.digits[0];
        b.BCD1 = p.digits[1];
        b.BCD2 = p.digits[2];
        b.BCD3 = p.digits[3];
      end
    end
    return b;
  endfunction

  assign bip_ok  = all_dec && (len == 5'd1) && (value.digits[0] <= 4'd1);
  assign time_ok = all_dec && (len == 5'd1 || len == 5'd2) && (dec >= MIN_T) && (dec <= MAX_T);
  assign pin_ok  = all_dec && (len >= 5'd4) && (len <= 5'd12);

  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    cfg_d   = cfg_q;
    ok_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (setup_on) state_d = ST_AUTH;
      end
      ST_AUTH: begin
        if (digitos_valid) begin
          if (key == KEY_STAR) begin
            state_d = (value == cfg_q.master) ? ST_CFG : ST_IDLE;
            scr_d   = 3'd0;
          end else if (key == KEY_HASH) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_CFG: begin
        if (digitos_valid && key == KEY_STAR) begin
          // Invalid or empty entries leave the field untouched but still advance.
          case (scr_q)
            3'd0:    if (bip_ok)  cfg_d.bip_status = value.digits[0][0];
            3'd1:    if (time_ok) cfg_d.bip_time   = dec;
            3'd2:    if (time_ok) cfg_d.lock_time  = dec;
            3'd3:    if (pin_ok)  cfg_d.master     = value;
            3'd4:    if (pin_ok)  cfg_d.pin1       = value;
            3'd5:    if (pin_ok)  cfg_d.pin2       = value;
            3'd6:    if (pin_ok)  cfg_d.pin3       = value;
            default: if (pin_ok)  cfg_d.pin4       = value;
          endcase
          scr_d = scr_q + 3'd1;
        end else if (digitos_valid && key == KEY_HASH) begin
          state_d = ST_IDLE;
          ok_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    en_d  = (state_d != ST_IDLE);
    bcd_d = screen_bcd(state_d, scr_d, cfg_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      scr_q   <= 3'd0;
      cfg_q   <= default_cfg();
      bcd_q   <= '1;
      en_q    <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      cfg_q   <= cfg_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
      ok_q    <= ok_d;
    end
  end

  assign display_en     = en_q;
  assign bcd_pac        = bcd_q;
  assign data_setup_new = cfg_q;
  assign data_setup_ok  = ok_q;

endmodule

// File: tb/tb_setup.sv
// Bench for the setup controller: directed scenarios plus randomized sessions
// checked against a string/integer model of the configuration screens.
module tb_setup;
  import setup_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      setup_on = 1'b0;
  logic      digitos_valid = 1'b0;
  senhaPac_t digitos_value;
  logic      display_en;
  bcdPac_t   bcd_pac;
  setupPac_t data_setup_new;
  logic      data_setup_ok;

  int checks = 0;
  int failures = 0;

  logic [19:0][3:0] kbuf;

  // Reference model: mode -1 idle, 0 auth, 1..8 configuration screen.
  int    m_mode;
  int    m_bip, m_bt, m_lt;
  string m_master;
  string m_pin[4];
  bit    m_ok;

  setup dut (
    .clk            (clk),
    .rst            (rst),
    .setup_on       (setup_on),
    .digitos_value  (digitos_value),
    .digitos_valid  (digitos_valid),
    .display_en     (display_en),
    .bcd_pac        (bcd_pac),
    .data_setup_new (data_setup_new),
    .data_setup_ok  (data_setup_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    m_mode = -1; m_bip = 1; m_bt = 5; m_lt = 5; m_master = "1234"; m_ok = 0;
    for (int i = 0; i < 4; i++) m_pin[i] = "";
  endfunction

  function automatic bit all_digits(input string s);
    for (int i = 0; i < s.len(); i++) if (s[i] < 8'd48 || s[i] > 8'd57) return 0;
    return 1;
  endfunction

  function automatic void model_key(input logic [3:0] k, input string s);
    int v;
    m_ok = 0;
    if (m_mode < 0) return;
    if (m_mode == 0) begin
      if (k == KEY_STAR) m_mode = (s == m_master) ? 1 : -1;
      else if (k == KEY_HASH) m_mode = -1;
      return;
    end
    if (k == KEY_HASH) begin
      m_mode = -1;
      m_ok = 1;
    end else if (k == KEY_STAR) begin
      v = s.atoi();
      if (s.len() > 0 && all_digits(s)) begin
        case (m_mode)
          1: if (s == "0" || s == "1") m_bip = v;
          2: if (s.len() <= 2 && v >= 5 && v <= 60) m_bt = v;
          3: if (s.len() <= 2 && v >= 5 && v <= 60) m_lt = v;
          default: if (s.len() >= 4 && s.len() <= 12) begin
            if (m_mode == 4) m_master = s;
            else m_pin[m_mode-5] = s;
          end
        endcase
      end
      m_mode = (m_mode % 8) + 1;
    end
  endfunction

  function automatic senhaPac_t pin_pack(input string s);
    senhaPac_t p;
    int l;
    p = '1;
    l = s.len();
    for (int i = 0; i < l; i++) p.digits[i] = 4'(s[l-1-i] - 8'd48);
    return p;
  endfunction

  function automatic setupPac_t exp_cfg();
    setupPac_t c;
    c.bip_status = 1'(m_bip);
    c.bip_time   = 7'(m_bt);
    c.lock_time  = 7'(m_lt);
    c.master     = pin_pack(m_master);
    c.pin1       = pin_pack(m_pin[0]);
    c.pin2       = pin_pack(m_pin[1]);
    c.pin3       = pin_pack(m_pin[2]);
    c.pin4       = pin_pack(m_pin[3]);
    return c;
  endfunction

  function automatic bcdPac_t exp_bcd();
    int    e[4];
    int    t, l;
    string s;
    bcdPac_t b;
    b = '1;
    for (int i = 0; i < 4; i++) e[i] = 15;
    if (m_mode >= 0) begin
      b.BCD5 = 4'(m_mode);
      if (m_mode == 1) e[0] = m_bip;
      else if (m_mode == 2 || m_mode == 3) begin
        t = (m_mode == 2) ? m_bt : m_lt;
        e[0] = t % 10;
        if (t >= 10) e[1] = t / 10;
      end else if (m_mode >= 4) begin
        s = (m_mode == 4) ? m_master : m_pin[m_mode-5];
        l = s.len();
        for (int k = 0; k < 4; k++) if (k < l) e[k] = s[l-1-k] - 8'd48;
      end
    end
    b.BCD0 = 4'(e[0]); b.BCD1 = 4'(e[1]); b.BCD2 = 4'(e[2]); b.BCD3 = 4'(e[3]);
    return b;
  endfunction

  function automatic string rand_digits(input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
    return s;
  endfunction

  function automatic string rand_entry(input int mode);
    int n;
    if (mode == 1 && $urandom_range(0, 1) == 1) return $sformatf("%0d", $urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0: n = 0;
      1: n = 1;
      2: n = 2;
      default: n = $urandom_range(3, 13);
    endcase
    return rand_digits(n);
  endfunction

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    kbuf = {kbuf[18:0], k};
    digitos_value.digits = kbuf;
    digitos_valid = 1'b1;
    @(negedge clk);
    digitos_valid = 1'b0;
    if (k == KEY_STAR || k == KEY_HASH) kbuf = '1;
  endtask

  task automatic type_entry(input string s, input logic [3:0] k);
    for (int i = 0; i < s.len(); i++) press(4'(s[i] - 8'd48));
    press(k);
    model_key(k, s);
  endtask

  task automatic enter_setup();
    @(negedge clk);
    setup_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    setup_on = 1'b0;
    if (m_mode < 0) m_mode = 0;
    m_ok = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    kbuf = '1;
    digitos_value.digits = '1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    kbuf = '1;
    digitos_value.digits = '1;
    #12;
    checks++; if (display_en !== 1'b0) begin failures++; $display("FAIL reset_display_en: got %b expected 0", display_en); end
    checks++; if (bcd_pac !== bcdPac_t'('1)) begin failures++; $display("FAIL reset_bcd: got %h expected all F", bcd_pac); end
    checks++; if (data_setup_ok !== 1'b0) begin failures++; $display("FAIL reset_ok: got %b expected 0", data_setup_ok); end
    checks++; if (data_setup_new !== exp_cfg()) begin failures++; $display("FAIL reset_cfg: got %h expected %h", data_setup_new, exp_cfg()); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_auth();
    enter_setup();
    checks++; if (display_en !== 1'b1) begin failures++; $display("FAIL auth_display_en: got %b expected 1", display_en); end
    checks++; if (bcd_pac !== exp_bcd()) begin failures++; $display("FAIL auth_bcd: got %h expected %h", bcd_pac, exp_bcd()); end
    type_entry("1234", KEY_STAR);
    checks++; if (bcd_pac.BCD5 !== 4'd1) begin failures++; $display("FAIL auth_ok_bcd5: got %h expected 1", bcd_pac.BCD5); end
    checks++; if (bcd_pac !== exp_bcd()) begin failures++; $display("FAIL cfg1_bcd: got %h expected %h", bcd_pac, exp_bcd()); end
    checks++; if (data_setup_new !== exp_cfg()) begin failures++; $display("FAIL auth_cfg: got %h expected %h", data_setup_new, exp_cfg()); end
  endtask

  task automatic test_walk();
    for (int i = 0; i < 8; i++) begin
      type_entry("", KEY_STAR);
      checks++;
      if (bcd_pac.BCD5 !== 4'((i + 1) % 8 + 1) || bcd_pac !== exp_bcd()) begin
        failures++; $display("FAIL walk_screen%0d: got %h expected %h", i, bcd_pac, exp_bcd());
      end
    end
    type_entry("", KEY_HASH);
    checks++; if (data_setup_ok !== 1'b1) begin failures++; $display("FAIL walk_ok_pulse: got %b expected 1", data_setup_ok); end
    checks++; if (display_en !== 1'b0) begin failures++; $display("FAIL walk_exit_en: got %b expected 0", display_en); end
    checks++; if (bcd_pac !== bcdPac_t'('1)) begin failures++; $display("FAIL walk_exit_bcd: got %h expected all F", bcd_pac); end
    checks++; if (data_setup_new !== exp_cfg()) begin failures++; $display("FAIL walk_cfg: got %h expected %h", data_setup_new, exp_cfg()); end
    @(negedge clk);
    checks++; if (data_setup_ok !== 1'b0) begin failures++; $display("FAIL walk_ok_width: got %b expected 0", data_setup_ok); end
  endtask

  task automatic test_fields();
    enter_setup();
    type_entry("1234", KEY_STAR);
    type_entry("0", KEY_STAR);
    type_entry("30", KEY_STAR);
    checks++; if (bcd_pac !== exp_bcd()) begin failures++; $display("FAIL fields_bcd: got %h expected %h", bcd_pac, exp_bcd()); end
    type_entry("", KEY_HASH);
    checks++; if (data_setup_new.bip_status !== 1'b0 || data_setup_new.bip_time !== 7'd30) begin
      failures++; $display("FAIL fields_values: got bip=%b time=%0d expected 0 30", data_setup_new.bip_status, data_setup_new.bip_time);
    end
    checks++; if (data_setup_new !== exp_cfg()) begin failures++; $display("FAIL fields_cfg: got %h expected %h", data_setup_new, exp_cfg()); end
  endtask

  task automatic test_range();
    enter_setup();
    type_entry("1234", KEY_STAR);
    type_entry("", KEY_STAR);
    type_entry("", KEY_STAR);
    type_entry("99", KEY_STAR);
    checks++; if (bcd_pac.BCD5 !== 4'd4) begin failures++; $display("FAIL range_bcd5: got %h expected 4", bcd_pac.BCD5); end
    checks++; if (data_setup_new.lock_time !== 7'd5) begin failures++; $display("FAIL range_lock: got %0d expected 5", data_setup_new.lock_time); end
    type_entry("", KEY_HASH);
  endtask

  task automatic test_bad_master();
    enter_setup();
    type_entry("9999", KEY_STAR);
    checks++; if (display_en !== 1'b0) begin failures++; $display("FAIL badm_en: got %b expected 0", display_en); end
    checks++; if (data_setup_ok !== 1'b0) begin failures++; $display("FAIL badm_ok: got %b expected 0", data_setup_ok); end
    checks++; if (bcd_pac !== bcdPac_t'('1)) begin failures++; $display("FAIL badm_bcd: got %h expected all F", bcd_pac); end
  endtask

  task automatic test_change_master();
    enter_setup();
    type_entry("1234", KEY_STAR);
    for (int i = 0; i < 3; i++) type_entry("", KEY_STAR);
    type_entry("5678", KEY_STAR);
    type_entry("", KEY_HASH);
    checks++; if (data_setup_new !== exp_cfg()) begin failures++; $display("FAIL chm_cfg: got %h expected %h", data_setup_new, exp_cfg()); end
    enter_setup();
    type_entry("1234", KEY_STAR);
    checks++; if (display_en !== 1'b0) begin failures++; $display("FAIL chm_old_rejected: got %b expected 0", display_en); end
    enter_setup();
    type_entry("5678", KEY_STAR);
    checks++; if (bcd_pac.BCD5 !== 4'd1 || display_en !== 1'b1) begin
      failures++; $display("FAIL chm_new_accepted: got bcd5=%h en=%b expected 1 1", bcd_pac.BCD5, display_en);
    end
    type_entry("", KEY_HASH);
  endtask

  task automatic test_idle_ignore();
    type_entry("5678", KEY_STAR);
    checks++; if (display_en !== 1'b0 || data_setup_ok !== 1'b0 || bcd_pac !== bcdPac_t'('1)) begin
      failures++; $display("FAIL idle_ignore: got en=%b ok=%b bcd=%h expected 0 0 all F", display_en, data_setup_ok, bcd_pac);
    end
  endtask

  task automatic test_async_reset();
    enter_setup();
    type_entry(m_master, KEY_STAR);
    type_entry("1", KEY_STAR);
    type_entry("42", KEY_STAR);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    kbuf = '1;
    #1;
    checks++; if (display_en !== 1'b0 || bcd_pac !== bcdPac_t'('1)) begin
      failures++; $display("FAIL async_reset_out: got en=%b bcd=%h expected 0 all F", display_en, bcd_pac);
    end
    checks++; if (data_setup_new !== exp_cfg()) begin failures++; $display("FAIL async_reset_cfg: got %h expected %h", data_setup_new, exp_cfg()); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int sessions = 0;
    int steps = 0;
    string s;
    while (sessions < 30) begin
      if (m_mode < 0) begin
        enter_setup();
        sessions++;
        steps = 0;
      end else if (m_mode == 0) begin
        s = ($urandom_range(0, 3) == 0) ? rand_digits(4) : m_master;
        type_entry(s, ($urandom_range(0, 9) == 0) ? KEY_HASH : KEY_STAR);
      end else begin
        steps++;
        if (steps > 12 || $urandom_range(0, 9) == 0) type_entry(rand_entry(m_mode), KEY_HASH);
        else type_entry(rand_entry(m_mode), KEY_STAR);
      end
      checks++;
      if (bcd_pac !== exp_bcd() || display_en !== (m_mode >= 0) || data_setup_ok !== m_ok ||
          data_setup_new !== exp_cfg()) begin
        failures++;
        $display("FAIL random_s%0d: got en=%b ok=%b bcd=%h expected en=%b ok=%b bcd=%h", sessions,
                 display_en, data_setup_ok, bcd_pac, (m_mode >= 0), m_ok, exp_bcd());
      end
      if (m_ok) begin
        @(negedge clk);
        checks++;
        if (data_setup_ok !== 1'b0) begin failures++; $display("FAIL random_ok_width: got %b expected 0", data_setup_ok); end
        m_ok = 0;
      end
    end
  endtask

  initial begin
    kbuf = '1;
    digitos_value.digits = '1;
    test_reset();
    test_auth();
    test_walk();
    test_fields();
    test_range();
    test_bad_master();
    test_change_master();
    test_idle_ignore();
    test_async_reset();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
